// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI instruction decoder: command byte layout,
// FSM state encoding and the default highest legal register address.
package spi_cmd_pkg;

   localparam int CMD_RW_BIT = 7;
   localparam int CMD_HI_BIT = 6;

   localparam logic [5:0] MAX_ADDR_DEFAULT = 6'h14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      RDATA = 2'd2
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to RESET_VAL.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_instr_decoder.sv
// Decodes two-byte SPI transactions (command, data) into one-cycle register-bank
// read/write strobes and returns read data to the SPI bridge.
module spi_instr_decoder
   import spi_cmd_pkg::*;
#(
   parameter int               ADDR_W   = 6,
   parameter logic [ADDR_W-1:0] MAX_ADDR = MAX_ADDR_DEFAULT[ADDR_W-1:0]
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_sync,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   input  logic              cs_n,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   output logic              hi_sel,
   output logic [7:0]        data_write,
   input  logic [7:0]        data_read
);

   state_t            state_q, state_d;
   logic              cs_sync, cs_prev, abort;
   logic              accept_cmd, wdata_byte;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_skip, cmd_is_write;
   logic              skip_q;
   logic [1:0]        cap_q, cap_zero_q;

   sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
      .clk (clk),
      .rst (rst),
      .d   (cs_n),
      .q   (cs_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) cs_prev <= 1'b1;
      else     cs_prev <= cs_sync;
   end

   // A rising edge of chip select ends the transaction early.
   assign abort        = cs_sync & ~cs_prev;
   assign cmd_addr     = data_in[ADDR_W-1:0];
   assign cmd_skip     = cmd_addr > MAX_ADDR;
   assign cmd_is_write = data_in[CMD_RW_BIT];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      accept_cmd = 1'b0;
      wdata_byte = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else if (byte_sync) begin
         unique case (state_q)
            IDLE: begin
               accept_cmd = 1'b1;
               state_d    = cmd_is_write ? WDATA : RDATA;
            end
            WDATA: begin
               wdata_byte = ~skip_q;
               state_d    = IDLE;
            end
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         read       <= 1'b0;
         write      <= 1'b0;
         addr       <= '0;
         hi_sel     <= 1'b0;
         data_write <= 8'h00;
         data_out   <= 8'h00;
         skip_q     <= 1'b0;
         cap_q      <= 2'b00;
         cap_zero_q <= 2'b00;
      end else begin
         state_q <= state_d;
         read    <= accept_cmd & ~cmd_is_write & ~cmd_skip;
         write   <= wdata_byte;
         // Legal reads load bank data two cycles after the command; illegal commands load zero.
         cap_q      <= {cap_q[0], accept_cmd & (~cmd_is_write | cmd_skip)};
         cap_zero_q <= {cap_zero_q[0], cmd_skip};
         if (accept_cmd) begin
            addr   <= cmd_addr;
            hi_sel <= data_in[CMD_HI_BIT];
            skip_q <= cmd_skip;
         end
         if (wdata_byte) data_write <= data_in;
         if (cap_q[1])   data_out   <= cap_zero_q[1] ? 8'h00 : data_read;
      end
   end

endmodule
